// File: rtl/lpif_rx_pkg.sv
// Shared types and sizing helpers for the half-rate LPIF receive path.
package lpif_rx_pkg;

  localparam int unsigned LPIF_HALF_WIDTH = 84;

  typedef enum logic [1:0] {
    RX_OFFLINE,
    RX_INIT,
    RX_ONLINE
  } rx_state_t;

  // One spare code above DEPTH so an over-count is representable and visible.
  function automatic int unsigned credit_ctr_width(input int unsigned depth);
    return $clog2(depth + 2);
  endfunction

endpackage

// File: rtl/lpif_rx_credit_ctr.sv
// Pending-credit counter: one pulse per pending credit, reload on link-up.
module lpif_rx_credit_ctr
  import lpif_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW = credit_ctr_width(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic inc,
  output logic credit,
  output logic init_done
);

  logic [CW-1:0] pending_q, pending_d;

  always_comb begin
    credit = (pending_q != '0);
    if (clear) begin
      pending_d = '0;
    end else if (load) begin
      pending_d = CW'(DEPTH);
    end else begin
      pending_d = pending_q + CW'(inc) - CW'(credit);
    end
    init_done = (pending_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  pending_le_depth: assert property (@(posedge clk) disable iff (!rst_n)
    pending_q <= CW'(DEPTH));

endmodule

// File: rtl/lpif_rxfifo_credit_half.sv
// Rx buffer in front of the half-rate asym1 unpacker; returns one credit per freed slot.
module lpif_rxfifo_credit_half
  import lpif_rx_pkg::*;
#(
  parameter int unsigned WIDTH = LPIF_HALF_WIDTH,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AWIDTH = $clog2(DEPTH)
) (
  input  logic              clk_wr,
  input  logic              rst_wr_n,
  input  logic              rx_online,
  input  logic [WIDTH-1:0]  rxfifo_i_data,
  input  logic              rxfifo_i_push,
  output logic [WIDTH-1:0]  rxfifo_upstream_data,
  output logic              user_upstream_vld,
  input  logic              user_upstream_ready,
  output logic              tx_i_credit,
  output logic [AWIDTH:0]   rx_fifo_count,
  output logic              rx_overflow
);

  localparam int unsigned CNTW = AWIDTH + 1;

  rx_state_t state_q, state_d;

  logic              fifo_en, flush, cred_load, cred_clear, init_done;
  logic              push_req, push_ok, pop, full;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic              ovf_q, ovf_d;

  // FSM: state register
  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      state_q <= RX_OFFLINE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_OFFLINE: if (rx_online) state_d = RX_INIT;
      RX_INIT: begin
        if (!rx_online)     state_d = RX_OFFLINE;
        else if (init_done) state_d = RX_ONLINE;
      end
      RX_ONLINE: if (!rx_online) state_d = RX_OFFLINE;
      default: state_d = RX_OFFLINE;
    endcase
  end

  // FSM: outputs. A falling rx_online flushes on the same edge that leaves INIT/ONLINE.
  always_comb begin
    fifo_en    = (state_q != RX_OFFLINE) && rx_online;
    flush      = !fifo_en;
    cred_load  = (state_q == RX_OFFLINE) && rx_online;
    cred_clear = !rx_online;
  end

  lpif_rx_credit_ctr #(
    .DEPTH (DEPTH)
  ) u_credit_ctr (
    .clk       (clk_wr),
    .rst_n     (rst_wr_n),
    .clear     (cred_clear),
    .load      (cred_load),
    .inc       (pop && fifo_en),
    .credit    (tx_i_credit),
    .init_done (init_done)
  );

  always_comb begin
    full     = (count_q == CNTW'(DEPTH));
    pop      = user_upstream_vld && user_upstream_ready;
    push_req = fifo_en && rxfifo_i_push;
    push_ok  = push_req && (!full || pop);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AWIDTH'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + AWIDTH'(1);
      count_d = count_q + CNTW'(push_ok) - CNTW'(pop);
      if (push_req && !push_ok) ovf_d = 1'b1;
      // Next head is the incoming word when it lands in the slot the read pointer moves to.
      if (count_d != '0) begin
        data_d = (push_ok && (rd_ptr_d == wr_ptr_q)) ? rxfifo_i_data : mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk_wr) begin
    if (push_ok) mem[wr_ptr_q] <= rxfifo_i_data;
  end

  always_ff @(posedge clk_wr) begin
    if (!rst_wr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  assign rxfifo_upstream_data = data_q;
  assign user_upstream_vld    = (count_q != '0);
  assign rx_fifo_count        = count_q;
  assign rx_overflow          = ovf_q;

endmodule

// File: tb/tb_lpif_rxfifo_credit_half.sv
// Scoreboard bench for lpif_rxfifo_credit_half: directed pushes, monitor checks pops and credits.
module tb_lpif_rxfifo_credit_half;
  import lpif_rx_pkg::*;

  localparam int unsigned WIDTH = 84;
  localparam int unsigned DEPTH = 8;

  logic             clk_wr = 1'b0;
  logic             rst_wr_n = 1'b0;
  logic             rx_online = 1'b0;
  logic [WIDTH-1:0] rxfifo_i_data = '0;
  logic             rxfifo_i_push = 1'b0;
  logic [WIDTH-1:0] rxfifo_upstream_data;
  logic             user_upstream_vld;
  logic             user_upstream_ready = 1'b0;
  logic             tx_i_credit;
  logic [3:0]       rx_fifo_count;
  logic             rx_overflow;

  lpif_rxfifo_credit_half #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_wr               (clk_wr),
    .rst_wr_n             (rst_wr_n),
    .rx_online            (rx_online),
    .rxfifo_i_data        (rxfifo_i_data),
    .rxfifo_i_push        (rxfifo_i_push),
    .rxfifo_upstream_data (rxfifo_upstream_data),
    .user_upstream_vld    (user_upstream_vld),
    .user_upstream_ready  (user_upstream_ready),
    .tx_i_credit          (tx_i_credit),
    .rx_fifo_count        (rx_fifo_count),
    .rx_overflow          (rx_overflow)
  );

  always #5 clk_wr = ~clk_wr;

  int cyc = 0;
  always @(posedge clk_wr) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               cred_q[$];
  bit               credit_track = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk_wr);
    #1;
  endtask

  // Monitor: pops are checked against the data queue; each pop schedules a credit one cycle later.
  always @(negedge clk_wr) begin : mon
    logic [WIDTH-1:0] e;
    int c;
    if (rst_wr_n) begin
      if (credit_track && tx_i_credit) begin
        if (cred_q.size() == 0) chk("credit_unexpected", 128'(cyc), 128'(0));
        else begin
          c = cred_q.pop_front();
          chk("credit_cycle", 128'(cyc), 128'(c));
        end
      end
      if (user_upstream_vld && user_upstream_ready) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 128'(rxfifo_upstream_data), 128'(0));
        else begin
          e = exp_q.pop_front();
          chk("pop_data", 128'(rxfifo_upstream_data), 128'(e));
        end
        if (credit_track) cred_q.push_back(cyc + 1);
      end
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] d, input bit expect_pop);
    rxfifo_i_push = 1'b1;
    rxfifo_i_data = d;
    if (expect_pop) exp_q.push_back(d);
    step();
    rxfifo_i_push = 1'b0;
  endtask

  // Link rise: expect exactly DEPTH pulses on the cycles right after the rise.
  task automatic online_rise(input string name);
    logic [9:0] pulses;
    pulses = '0;
    rx_online = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses[i] = tx_i_credit;
    end
    chk({name, "_credits"}, 128'(pulses), 128'(10'h0FF));
    chk({name, "_state"}, 128'(dut.state_q), 128'(RX_ONLINE));
    chk({name, "_count"}, 128'(rx_fifo_count), 128'(0));
    chk({name, "_vld"}, 128'(user_upstream_vld), 128'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // Reset and offline behaviour
    repeat (3) step();
    rst_wr_n = 1'b1;
    step();
    chk("rst_vld", 128'(user_upstream_vld), 128'(0));
    chk("rst_count", 128'(rx_fifo_count), 128'(0));
    chk("rst_credit", 128'(tx_i_credit), 128'(0));
    chk("rst_ovf", 128'(rx_overflow), 128'(0));
    chk("rst_data", 128'(rxfifo_upstream_data), 128'(0));
    rxfifo_i_push = 1'b1;
    rxfifo_i_data = 84'h3C;
    repeat (5) step();
    rxfifo_i_push = 1'b0;
    chk("offline_count", 128'(rx_fifo_count), 128'(0));
    chk("offline_ovf", 128'(rx_overflow), 128'(0));
    chk("offline_credit", 128'(tx_i_credit), 128'(0));

    online_rise("init1");

    // Three words held, then drained with credits one cycle after each pop
    credit_track = 1'b1;
    push_word(84'h1, 1'b1);
    push_word(84'h2, 1'b1);
    push_word(84'h3, 1'b1);
    chk("t2_count", 128'(rx_fifo_count), 128'(3));
    chk("t2_vld", 128'(user_upstream_vld), 128'(1));
    chk("t2_head", 128'(rxfifo_upstream_data), 128'(1));
    repeat (2) step();
    chk("t2_hold", 128'(rxfifo_upstream_data), 128'(1));
    user_upstream_ready = 1'b1;
    repeat (3) step();
    user_upstream_ready = 1'b0;
    repeat (3) step();
    chk("t2_empty", 128'(rx_fifo_count), 128'(0));
    chk("t2_last_hold", 128'(rxfifo_upstream_data), 128'(3));
    chk("t2_credits_done", 128'(cred_q.size()), 128'(0));

    // Fill, overflow drop, then push accepted at full thanks to a same-cycle pop
    for (int i = 0; i < 8; i++) push_word(84'h10 + 84'(i), 1'b1);
    chk("t3_full", 128'(rx_fifo_count), 128'(8));
    push_word(84'hAA, 1'b0);
    chk("t3_drop_count", 128'(rx_fifo_count), 128'(8));
    chk("t3_ovf", 128'(rx_overflow), 128'(1));
    user_upstream_ready = 1'b1;
    push_word(84'hBB, 1'b1);
    chk("t3_full_pushpop", 128'(rx_fifo_count), 128'(8));
    repeat (8) step();
    user_upstream_ready = 1'b0;
    repeat (2) step();
    chk("t3_drained", 128'(rx_fifo_count), 128'(0));
    chk("t3_ovf_sticky", 128'(rx_overflow), 128'(1));
    chk("t3_credits_done", 128'(cred_q.size()), 128'(0));

    // Streaming push+pop across several pointer wraps; first push into empty is not bypassed
    user_upstream_ready = 1'b1;
    rxfifo_i_push = 1'b1;
    for (int i = 0; i < 21; i++) begin
      rxfifo_i_data = 84'h100 + 84'(i);
      exp_q.push_back(rxfifo_i_data);
      step();
      chk("t4_count", 128'(rx_fifo_count), 128'(1));
    end
    rxfifo_i_push = 1'b0;
    step();
    user_upstream_ready = 1'b0;
    repeat (2) step();
    chk("t4_empty", 128'(rx_fifo_count), 128'(0));
    chk("t4_credits_done", 128'(cred_q.size()), 128'(0));
    credit_track = 1'b0;

    // Link drop in INIT with traffic in flight
    rx_online = 1'b0;
    step();
    rx_online = 1'b1;
    step();                       // INIT, pending 8
    chk("t5_init_state", 128'(dut.state_q), 128'(RX_INIT));
    user_upstream_ready = 1'b1;
    push_word(84'h55, 1'b1);      // pending 7, 0x55 at head
    push_word(84'h66, 1'b0);      // 0x55 popped, 0x66 flushed later
    user_upstream_ready = 1'b0;
    chk("t5_credit_before", 128'(tx_i_credit), 128'(1));
    rx_online = 1'b0;
    step();
    chk("t5_credit_stop", 128'(tx_i_credit), 128'(0));
    chk("t5_flush_count", 128'(rx_fifo_count), 128'(0));
    chk("t5_flush_vld", 128'(user_upstream_vld), 128'(0));
    chk("t5_offline", 128'(dut.state_q), 128'(RX_OFFLINE));
    step();
    chk("t5_credit_quiet", 128'(tx_i_credit), 128'(0));
    online_rise("init2");

    // Reset mid-traffic
    for (int i = 0; i < 5; i++) push_word(84'h200 + 84'(i), 1'b0);
    chk("t6_count5", 128'(rx_fifo_count), 128'(5));
    rxfifo_i_push = 1'b1;
    rst_wr_n = 1'b0;
    step();
    rxfifo_i_push = 1'b0;
    rx_online = 1'b0;
    chk("t6_count", 128'(rx_fifo_count), 128'(0));
    chk("t6_vld", 128'(user_upstream_vld), 128'(0));
    chk("t6_data", 128'(rxfifo_upstream_data), 128'(0));
    chk("t6_credit", 128'(tx_i_credit), 128'(0));
    chk("t6_ovf", 128'(rx_overflow), 128'(0));
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
